// File: rtl/x_delay_pkg.sv
// ============================================================================
// Package : x_delay_pkg
// Shared constants and types for the delay-line snapshot decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package x_delay_pkg;

  localparam int                  DL_WIDTH    = 32;
  localparam logic [DL_WIDTH-1:0] DL_ALT_MASK = 32'hAAAA_AAAA;

  typedef logic [5:0] depth_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/x_therm_decode.sv
// ============================================================================
// Module  : x_therm_decode
// Combinational decode of one delay-line snapshot: propagation depth (length
// of the leading run after un-alternating) and a bubble flag.
// Build option: X_DELAY_DECODE_BUBBLE_EN enables the bubble detector,
// otherwise o_bubble is tied low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module x_therm_decode
  import x_delay_pkg::*;
(
  input  logic [DL_WIDTH-1:0] i_data,
  output depth_t              o_depth,
  output logic                o_bubble
);

  logic [DL_WIDTH-1:0] w;
  logic [DL_WIDTH-1:0] run_zero;
  logic [5:0]          depth;
  logic                found;

  // Undo the inverter alternation, fold polarity so the leading run is zeros,
  // then find the first set bit (the transition stage).
  always_comb begin
    w        = i_data ^ DL_ALT_MASK;
    run_zero = w[0] ? ~w : w;
    depth    = 6'd32;
    found    = 1'b0;
    for (int k = 0; k < DL_WIDTH; k++) begin
      if (!found && run_zero[k]) begin
        depth = 6'(k);
        found = 1'b1;
      end
    end
  end

  assign o_depth = depth;

`ifdef X_DELAY_DECODE_BUBBLE_EN
  // Every stage from the transition upward must read 1 after folding; any 0
  // there is a bubble. A full-length run shifts both sides to zero.
  assign o_bubble = (run_zero >> depth) != ({DL_WIDTH{1'b1}} >> depth);
`else
  assign o_bubble = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/x_delay_decode.sv
// ============================================================================
// Module  : x_delay_decode
// Accumulates 2**LOG2_SAMPLES decoded delay-line depths per run into
// average/min/max/saturation (and optional bubble count) and presents them
// with a valid/ready handshake.
// Build option: X_DELAY_DECODE_BUBBLE_EN enables bubble counting; without it
// o_bubble_cnt stays 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module x_delay_decode #(
  parameter int LOG2_SAMPLES = 2,
  parameter int SKIP         = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [x_delay_pkg::DL_WIDTH-1:0] i_data,
  input  logic                          i_start,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [5:0]                    o_avg,
  output logic [5:0]                    o_min,
  output logic [5:0]                    o_max,
  output logic                          o_sat,
  output logic [7:0]                    o_bubble_cnt
);

  // The SKIP parameter shadows the enum literal of the same name, so the
  // skip state is always referenced with its package prefix.
  import x_delay_pkg::*;

  localparam int               NSAMP     = 1 << LOG2_SAMPLES;
  localparam int               SUM_W     = 6 + LOG2_SAMPLES;
  localparam int               CNT_W     = 16;
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP - 1);
  localparam logic [CNT_W-1:0] SAMP_CNT  = CNT_W'(NSAMP);

  depth_t     dec_depth;
  logic       dec_bubble;
  depth_t     d_q;
  logic       bub_sample;

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  depth_t           min_q, min_d, max_q, max_d;
  logic             sat_q, sat_d;
  logic [7:0]       bcnt_q, bcnt_d;
  depth_t           oavg_q, oavg_d, omin_q, omin_d, omax_q, omax_d;
  logic             osat_q, osat_d;
  logic [7:0]       obcnt_q, obcnt_d;

  x_therm_decode u_decode (
    .i_data   (i_data),
    .o_depth  (dec_depth),
    .o_bubble (dec_bubble)
  );

  // Decode pipeline register: every accumulation sees the previous cycle's snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) d_q <= '0;
    else          d_q <= dec_depth;
  end

`ifdef X_DELAY_DECODE_BUBBLE_EN
  logic bub_q;
  // Bubble flag travels alongside the registered depth.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) bub_q <= 1'b0;
    else          bub_q <= dec_bubble;
  end
  assign bub_sample = bub_q;
`else
  logic unused_bubble;
  assign unused_bubble = dec_bubble;
  assign bub_sample    = 1'b0;
`endif

  // State, accumulator and result registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      min_q   <= 6'd32;
      max_q   <= '0;
      sat_q   <= 1'b0;
      bcnt_q  <= '0;
      oavg_q  <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      osat_q  <= 1'b0;
      obcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      bcnt_q  <= bcnt_d;
      oavg_q  <= oavg_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      osat_q  <= osat_d;
      obcnt_q <= obcnt_d;
    end
  end

  // Next-state: ACCUM spends one extra cycle after the last sample to publish results.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (SKIP == 0) state_d = ACCUM;
          else           state_d = x_delay_pkg::SKIP;
        end
      end
      x_delay_pkg::SKIP: if (cnt_q == SKIP_LAST) state_d = ACCUM;
      ACCUM:             if (cnt_q == SAMP_CNT)  state_d = DONE;
      DONE:              if (i_ready)            state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Datapath/outputs: clear on run start, accumulate in ACCUM, publish on DONE entry.
  always_comb begin
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    sat_d   = sat_q;
    bcnt_d  = bcnt_q;
    oavg_d  = oavg_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    osat_d  = osat_q;
    obcnt_d = obcnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          cnt_d  = '0;
          sum_d  = '0;
          min_d  = 6'd32;
          max_d  = '0;
          sat_d  = 1'b0;
          bcnt_d = '0;
        end
      end
      x_delay_pkg::SKIP: begin
        cnt_d = (cnt_q == SKIP_LAST) ? '0 : cnt_q + 1'b1;
      end
      ACCUM: begin
        if (cnt_q == SAMP_CNT) begin
          oavg_d  = depth_t'(sum_q >> LOG2_SAMPLES);
          omin_d  = min_q;
          omax_d  = max_q;
          osat_d  = sat_q;
          obcnt_d = bcnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_q + SUM_W'(d_q);
          if (d_q < min_q) min_d = d_q;
          if (d_q > max_q) max_d = d_q;
          sat_d = sat_q | (d_q == 6'd32);
          if (bub_sample && (bcnt_q != 8'hFF)) bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign o_busy       = (state_q != IDLE);
  assign o_valid      = (state_q == DONE);
  assign o_avg        = oavg_q;
  assign o_min        = omin_q;
  assign o_max        = omax_q;
  assign o_sat        = osat_q;
  assign o_bubble_cnt = obcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_x_delay_decode.sv
// ============================================================================
// Module  : tb_x_delay_decode
// Self-checking bench for x_delay_decode (LOG2_SAMPLES=2, SKIP=2).
// Honours X_DELAY_DECODE_BUBBLE_EN for the expected bubble count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_delay_decode;

  localparam int L2  = 2;
  localparam int SK  = 2;
  localparam int NS  = 1 << L2;
  localparam int LAT = 1 + SK + 1 + NS;
`ifdef X_DELAY_DECODE_BUBBLE_EN
  localparam int BUB_ON = 1;
`else
  localparam int BUB_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, ready;
  logic [31:0] data;
  logic        busy, valid, sat;
  logic [5:0]  avg, mn, mx;
  logic [7:0]  bcnt;

  always #5 clk = ~clk;

  x_delay_decode #(.LOG2_SAMPLES(L2), .SKIP(SK)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_start      (start),
    .i_ready      (ready),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_avg        (avg),
    .o_min        (mn),
    .o_max        (mx),
    .o_sat        (sat),
    .o_bubble_cnt (bcnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] run_data [NS];

  typedef struct {
    logic [NS-1:0][31:0] s;
    int avg, mn, mx;
    bit sat;
    int bub;
  } vec_t;
  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: length of the leading run of equal stages after un-alternating.
  function automatic int ref_depth(input logic [31:0] x);
    logic [31:0] w;
    int n;
    w = x ^ 32'hAAAA_AAAA;
    n = 1;
    while (n < 32 && w[n] == w[0]) n++;
    return n;
  endfunction

  // Reference: any stage beyond the transition still showing the leading value.
  function automatic bit ref_bubble(input logic [31:0] x);
    logic [31:0] w;
    int d;
    w = x ^ 32'hAAAA_AAAA;
    d = ref_depth(x);
    for (int k = d; k < 32; k++) if (w[k] == w[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] gen_word();
    int r, idx;
    bit p;
    logic [31:0] w, low;
    r = $urandom_range(32, 1);
    p = 1'($urandom_range(1, 0));
    if (r == 32) w = {32{p}};
    else begin
      low = (32'h1 << r) - 32'h1;
      w   = p ? low : ~low;
    end
    if (r <= 30 && $urandom_range(3, 0) == 0) begin
      idx = $urandom_range(31, r + 1);
      w[idx] = ~w[idx];
    end
    return w ^ 32'hAAAA_AAAA;
  endfunction

  // One full run: start, SK discarded snapshots, NS samples, handshake.
  task automatic run_check(input string nm, input int e_avg, input int e_min, input int e_max,
                           input bit e_sat, input int e_bub, input int rdy_wait, input bit start_on_accept);
    bit early, stable;
    logic [5:0] h_avg, h_min, h_max;
    logic h_sat;
    logic [7:0] h_bcnt;
    early = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      data  = (j >= SK && j < SK + NS) ? run_data[j - SK] : $urandom;
      start = (j == 0) || (j % 2 == 1);
      step();
      if (j == 0) chk({nm, ".busy_after_start"}, 32'(busy), 32'd1);
      if (j + 1 < LAT && valid) early = 1'b1;
    end
    start = 1'b0;
    chk({nm, ".valid_early"}, 32'(early), 32'd0);
    chk({nm, ".valid_at_latency"}, 32'(valid), 32'd1);
    chk({nm, ".avg"}, 32'(avg), 32'(e_avg));
    chk({nm, ".min"}, 32'(mn), 32'(e_min));
    chk({nm, ".max"}, 32'(mx), 32'(e_max));
    chk({nm, ".sat"}, 32'(sat), 32'(e_sat));
    chk({nm, ".bubble_cnt"}, 32'(bcnt), 32'(e_bub));
    h_avg = avg; h_min = mn; h_max = mx; h_sat = sat; h_bcnt = bcnt;
    stable = 1'b1;
    for (int w = 0; w < rdy_wait; w++) begin
      data  = $urandom;
      start = 1'b1;
      ready = 1'b0;
      step();
      if (!valid || avg !== h_avg || mn !== h_min || mx !== h_max || sat !== h_sat || bcnt !== h_bcnt)
        stable = 1'b0;
    end
    chk({nm, ".hold_in_done"}, 32'(stable), 32'd1);
    ready = 1'b1;
    start = start_on_accept;
    step();
    ready = 1'b0;
    start = 1'b0;
    chk({nm, ".valid_after_accept"}, 32'(valid), 32'd0);
    chk({nm, ".busy_after_accept"}, 32'(busy), 32'd0);
    chk({nm, ".avg_kept_after_accept"}, 32'(avg), 32'(e_avg));
    step();
    chk({nm, ".idle_after_accept"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e_sum, e_min, e_max, e_bub, d;
    bit e_sat;

    tbl[0].s = {32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA};
    tbl[0].avg = 16; tbl[0].mn = 16; tbl[0].mx = 16; tbl[0].sat = 0; tbl[0].bub = 0;
    tbl[1].s = {32'h5555AAAA, 32'h5555AAAA, 32'h555555AA, 32'h555555AA};
    tbl[1].avg = 12; tbl[1].mn = 8;  tbl[1].mx = 16; tbl[1].sat = 0; tbl[1].bub = 0;
    tbl[2].s = {32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA, 32'hAAAAAAAA};
    tbl[2].avg = 20; tbl[2].mn = 16; tbl[2].mx = 32; tbl[2].sat = 1; tbl[2].bub = 0;
    tbl[3].s = {32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA};
    tbl[3].avg = 17; tbl[3].mn = 17; tbl[3].mx = 17; tbl[3].sat = 0; tbl[3].bub = 4 * BUB_ON;
    tbl[4].s = {32'hAAAAAA55, 32'hAAAAAA55, 32'hAAAAAA55, 32'hAAAAAA55};
    tbl[4].avg = 8;  tbl[4].mn = 8;  tbl[4].mx = 8;  tbl[4].sat = 0; tbl[4].bub = 0;
    tbl[5].s = {32'h0000AAAA, 32'hAAAAAAAA, 32'h5555AAAB, 32'h55555554};
    tbl[5].avg = 12; tbl[5].mn = 1;  tbl[5].mx = 32; tbl[5].sat = 1; tbl[5].bub = 2 * BUB_ON;

    rst_n = 1'b0; start = 1'b0; ready = 1'b0; data = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset.busy",  32'(busy),  32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.outs",  {16'(avg), 8'(mn), 8'(mx)}, 32'd0);
    chk("reset.sat_bcnt", {23'd0, sat, bcnt}, 32'd0);

    // Directed table (index 0 at element [0] of the packed list = last literal).
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < NS; k++) run_data[k] = tbl[v].s[k];
      run_check($sformatf("tbl%0d", v), tbl[v].avg, tbl[v].mn, tbl[v].mx, tbl[v].sat, tbl[v].bub,
                (v == 0) ? 10 : v % 3, v[0]);
    end

    // Mid-ACCUM reset aborts the run and clears everything.
    start = 1'b1; data = 32'hAAAAAAAA;
    step();
    start = 1'b0;
    for (int j = 1; j < SK + 3; j++) begin
      data = (j % 2 == 0) ? 32'hAAAAAAAA : 32'h55555554;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset.busy",  32'(busy),  32'd0);
    chk("midreset.valid", 32'(valid), 32'd0);
    chk("midreset.outs",  {16'(avg), 8'(mn), 8'(mx)}, 32'd0);
    chk("midreset.sat_bcnt", {23'd0, sat, bcnt}, 32'd0);
    for (int k = 0; k < NS; k++) run_data[k] = 32'h5555AAAA;
    run_check("after_reset", 16, 16, 16, 1'b0, 0, 1, 1'b0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      e_sum = 0; e_min = 99; e_max = 0; e_sat = 1'b0; e_bub = 0;
      for (int k = 0; k < NS; k++) begin
        run_data[k] = ($urandom_range(7, 0) == 0) ? $urandom : gen_word();
        d = ref_depth(run_data[k]);
        e_sum += d;
        if (d < e_min) e_min = d;
        if (d > e_max) e_max = d;
        if (d == 32) e_sat = 1'b1;
        if (BUB_ON != 0 && ref_bubble(run_data[k])) e_bub++;
      end
      run_check($sformatf("rnd%0d", r), e_sum / NS, e_min, e_max, e_sat, e_bub,
                $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
